// File: rtl/nes_controller_port.sv
// NES controller port ($4016/$4017) driven from a USB HID keycode.
// The keycode is synchronized and run-length filtered into an 8-bit button
// vector. CPU writes to $4016 control the strobe, and CPU reads of $4016
// shift the button vector out serially. $4017 reads as an absent second pad.
//
// Ports:
//   Clk            NES master clock; all state changes on its rising edge
//   Reset_n        asynchronous active-low reset
//   CPU_EN         one-cycle qualifier for a CPU bus access
//   CPU_ADDR       CPU address bus
//   CPU_DIN        CPU write data (only bit 0 is used)
//   CPU_RW_n       1 = read, 0 = write
//   keycode        USB HID keycode, asynchronous to Clk, 8'h00 = no key
//   CPU_DOUT       combinational read data (8'h00 when not driving)
//   CPU_DOUT_VALID high when CPU_DOUT must drive the CPU data bus
//   buttons_dbg    filtered button vector {Right,Left,Down,Up,Start,Select,B,A}
module nes_controller_port #(
    parameter logic [7:0]  OPEN_BUS       = 8'h40,
    parameter int unsigned STABLE_SAMPLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        CPU_EN,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DIN,
    input  logic        CPU_RW_n,
    input  logic [7:0]  keycode,
    output logic [7:0]  CPU_DOUT,
    output logic        CPU_DOUT_VALID,
    output logic [7:0]  buttons_dbg
);

    localparam int unsigned    CNT_W     = 4;
    localparam int unsigned    BTN_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES);
    localparam logic [15:0]    ADDR_JOY1 = 16'h4016;
    localparam logic [15:0]    ADDR_JOY2 = 16'h4017;

    logic [7:0]       kc_meta;
    logic [7:0]       sync_kc;
    logic [7:0]       kc_prev;
    logic [CNT_W-1:0] stable_cnt;
    logic [BTN_W-1:0] btn;
    logic             strobe;
    logic [BTN_W-1:0] shift_reg;
    logic             wr_joy1;
    logic             rd_joy1;
    logic             rd_joy2;
    logic             unused_din;

    // One-hot keycode to button map; unknown codes release every button.
    function automatic logic [BTN_W-1:0] decode_key(input logic [7:0] kc);
        logic [BTN_W-1:0] b;
        b = '0;
        case (kc)
            8'h0D:   b = 8'b0000_0001; // A
            8'h0E:   b = 8'b0000_0010; // B
            8'h2C:   b = 8'b0000_0100; // Select
            8'h28:   b = 8'b0000_1000; // Start
            8'h1A:   b = 8'b0001_0000; // Up
            8'h16:   b = 8'b0010_0000; // Down
            8'h04:   b = 8'b0100_0000; // Left
            8'h07:   b = 8'b1000_0000; // Right
            default: b = '0;
        endcase
        return b;
    endfunction

    // Two-flop synchronizer for the asynchronous keycode.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_meta <= '0;
            sync_kc <= '0;
        end else begin
            kc_meta <= keycode;
            sync_kc <= kc_meta;
        end
    end

    // Stability filter: btn loads once, in the cycle the run counter
    // reaches its saturation value; a single-sample glitch never gets there.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_prev    <= '0;
            stable_cnt <= '0;
            btn        <= '0;
        end else begin
            kc_prev <= sync_kc;
            if (sync_kc != kc_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
                if (stable_cnt == CNT_MAX - CNT_W'(1)) begin
                    btn <= decode_key(sync_kc);
                end
            end
        end
    end

    // Bus access qualification.
    always_comb begin
        wr_joy1 = CPU_EN && !CPU_RW_n && (CPU_ADDR == ADDR_JOY1);
        rd_joy1 = CPU_EN &&  CPU_RW_n && (CPU_ADDR == ADDR_JOY1);
        rd_joy2 = CPU_EN &&  CPU_RW_n && (CPU_ADDR == ADDR_JOY2);
    end

    assign unused_din = ^CPU_DIN[7:1];

    // Strobe and serial shifter. While strobe is high the shifter tracks btn
    // every cycle, so the falling-strobe write leaves it holding btn of that
    // cycle. Ones fill in from the top, giving bit0=1 after eight reads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            strobe    <= 1'b0;
            shift_reg <= '1;
        end else begin
            if (wr_joy1) begin
                strobe <= CPU_DIN[0];
            end
            if (strobe) begin
                shift_reg <= btn;
            end else if (rd_joy1) begin
                shift_reg <= {1'b1, shift_reg[BTN_W-1:1]};
            end
        end
    end

    // Combinational read path; while strobe is high bit0 is the live A button.
    always_comb begin
        CPU_DOUT_VALID = 1'b0;
        CPU_DOUT       = '0;
        if (Reset_n && rd_joy1) begin
            CPU_DOUT_VALID = 1'b1;
            CPU_DOUT       = OPEN_BUS | {7'b0, (strobe ? btn[0] : shift_reg[0])};
        end else if (Reset_n && rd_joy2) begin
            CPU_DOUT_VALID = 1'b1;
            CPU_DOUT       = {OPEN_BUS[7:1], 1'b0};
        end
    end

    assign buttons_dbg = btn;

endmodule

// File: tb/tb_nes_controller_port.sv
// Bench for nes_controller_port: directed scenarios plus a randomized phase,
// all checked against a run-length / read-index reference model.
module tb_nes_controller_port;

    localparam int unsigned S = 2;
    localparam logic [7:0] KEY_TAB [8] = '{8'h0D, 8'h0E, 8'h2C, 8'h28,
                                           8'h1A, 8'h16, 8'h04, 8'h07};

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        CPU_EN;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DIN;
    logic        CPU_RW_n;
    logic [7:0]  keycode;
    logic [7:0]  CPU_DOUT;
    logic        CPU_DOUT_VALID;
    logic [7:0]  buttons_dbg;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] kq0, kq1;     // keycode samples still in flight to the filter
    logic [7:0] last_x;
    int         run;
    logic [7:0] m_btn;
    logic       m_strobe;
    logic [7:0] m_lat;
    int         m_pos;        // reads taken since latch; 8 or more means exhausted

    nes_controller_port dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .CPU_EN         (CPU_EN),
        .CPU_ADDR       (CPU_ADDR),
        .CPU_DIN        (CPU_DIN),
        .CPU_RW_n       (CPU_RW_n),
        .keycode        (keycode),
        .CPU_DOUT       (CPU_DOUT),
        .CPU_DOUT_VALID (CPU_DOUT_VALID),
        .buttons_dbg    (buttons_dbg)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [7:0] kc);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (kc == KEY_TAB[i]) r = 8'(1) << i;
        end
        return r;
    endfunction

    task automatic model_reset();
        kq0 = 8'h00; kq1 = 8'h00; last_x = 8'h00; run = 1;
        m_btn = 8'h00; m_strobe = 1'b0; m_lat = 8'h00; m_pos = 8;
    endtask

    // One clock edge of the reference model, given the inputs seen at that edge.
    task automatic model_step(input logic en, input logic [15:0] addr, input logic [7:0] din,
                              input logic rw, input logic [7:0] kc);
        logic [7:0] x;
        logic [7:0] nb;
        x   = kq1;
        kq1 = kq0;
        kq0 = kc;
        if (x == last_x) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
        end
        last_x = x;
        nb = (run == int'(S) + 1) ? ref_decode(x) : m_btn;
        if (en && !rw && addr == 16'h4016) begin
            if (m_strobe && !din[0]) begin
                m_lat = m_btn;
                m_pos = 0;
            end
            m_strobe = din[0];
        end else if (en && rw && addr == 16'h4016 && !m_strobe && m_pos < 8) begin
            m_pos++;
        end
        m_btn = nb;
    endtask

    task automatic model_read(input logic en, input logic [15:0] addr, input logic rw,
                              output logic v, output logic [7:0] d);
        logic b;
        v = 1'b0;
        d = 8'h00;
        if (en && rw && addr == 16'h4016) begin
            b = m_strobe ? m_btn[0] : ((m_pos < 8) ? m_lat[m_pos] : 1'b1);
            v = 1'b1;
            d = 8'h40 | {7'b0, b};
        end else if (en && rw && addr == 16'h4017) begin
            v = 1'b1;
            d = 8'h40;
        end
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input logic en, input logic [15:0] addr, input logic [7:0] din,
                         input logic rw, input logic [7:0] kc,
                         output logic v, output logic [7:0] d);
        logic       ev;
        logic [7:0] ed;
        CPU_EN = en; CPU_ADDR = addr; CPU_DIN = din; CPU_RW_n = rw; keycode = kc;
        #1;
        model_read(en, addr, rw, ev, ed);
        chk("valid", 16'(CPU_DOUT_VALID), 16'(ev));
        chk("dout", 16'(CPU_DOUT), 16'(ed));
        v = CPU_DOUT_VALID;
        d = CPU_DOUT;
        @(posedge Clk);
        model_step(en, addr, din, rw, kc);
        @(negedge Clk);
        chk("buttons", 16'(buttons_dbg), 16'(m_btn));
    endtask

    task automatic idle(input logic [7:0] kc, input int n);
        logic v; logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 16'($urandom), 8'($urandom), 1'($urandom), kc, v, d);
        end
    endtask

    task automatic wr16(input logic [7:0] data, input logic [7:0] kc);
        logic v; logic [7:0] d;
        cycle(1'b1, 16'h4016, data, 1'b0, kc, v, d);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [7:0] kc,
                      output logic v, output logic [7:0] d);
        cycle(1'b1, addr, 8'h00, 1'b1, kc, v, d);
    endtask

    logic       rv;
    logic [7:0] rdat;

    initial begin
        Reset_n = 1'b1; CPU_EN = 1'b0; CPU_ADDR = 16'h0000; CPU_DIN = 8'h00;
        CPU_RW_n = 1'b1; keycode = 8'h00;
        model_reset();

        // reset state, with a qualified read presented during reset
        #2 Reset_n = 1'b0;
        CPU_EN = 1'b1; CPU_ADDR = 16'h4016; CPU_RW_n = 1'b1;
        #1;
        chk("rst_valid", 16'(CPU_DOUT_VALID), 16'h0);
        chk("rst_dout", 16'(CPU_DOUT), 16'h00);
        chk("rst_buttons", 16'(buttons_dbg), 16'h00);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1; CPU_EN = 1'b0;
        idle(8'h00, 8);

        // filtered key press: A then Right
        idle(8'h0D, 6);
        chk("key_a", 16'(buttons_dbg), 16'h01);
        idle(8'h07, 6);
        chk("key_right", 16'(buttons_dbg), 16'h80);

        // serial readout of btn=01 after a full strobe pulse
        idle(8'h0D, 6);
        wr16(8'h01, 8'h0D);
        wr16(8'hFE, 8'h0D);   // upper data bits must be ignored
        for (int i = 0; i < 9; i++) begin
            rd(16'h4016, 8'h0D, rv, rdat);
            chk("seq", 16'(rdat), (i == 0 || i == 8) ? 16'h41 : 16'h40);
        end

        // strobe held high while the keycode toggles 00/1A every cycle
        idle(8'h00, 8);
        wr16(8'h01, 8'h00);
        for (int i = 0; i < 6; i++) begin
            rd(16'h4016, (i % 2 == 0) ? 8'h1A : 8'h00, rv, rdat);
            chk("strobe_rd", 16'(rdat), 16'h40);
        end
        idle(8'h00, 2);
        chk("toggle_btn", 16'(buttons_dbg), 16'h00);
        wr16(8'h00, 8'h00);
        for (int i = 0; i < 9; i++) begin
            rd(16'h4016, 8'h00, rv, rdat);
            chk("seq_zero", 16'(rdat), (i == 8) ? 16'h41 : 16'h40);
        end

        // one-cycle glitch to Start between idle samples
        idle(8'h00, 6);
        idle(8'h28, 1);
        idle(8'h00, 8);
        chk("glitch", 16'(buttons_dbg), 16'h00);

        // $4017, unmapped addresses and unqualified cycles
        idle(8'h0E, 6);
        wr16(8'h01, 8'h0E);
        wr16(8'h00, 8'h0E);
        rd(16'h4016, 8'h0E, rv, rdat);
        chk("b_rd0", 16'(rdat), 16'h40);
        rd(16'h4017, 8'h0E, rv, rdat);
        chk("j2_dout", 16'(rdat), 16'h40);
        chk("j2_valid", 16'(rv), 16'h1);
        rd(16'h5000, 8'h0E, rv, rdat);
        chk("unmap_valid", 16'(rv), 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h4016, 8'h00, 1'b1, 8'h0E, rv, rdat);
            chk("noen_valid", 16'(rv), 16'h0);
        end
        cycle(1'b1, 16'h4017, 8'h00, 1'b0, 8'h0E, rv, rdat);  // frame counter write
        rd(16'h4016, 8'h0E, rv, rdat);
        chk("b_rd1", 16'(rdat), 16'h41);
        rd(16'h4016, 8'h0E, rv, rdat);
        chk("b_rd2", 16'(rdat), 16'h40);
        wr16(8'h00, 8'h0E);   // 0 -> 0 write keeps the position
        rd(16'h4016, 8'h0E, rv, rdat);
        chk("b_rd3", 16'(rdat), 16'h40);

        // reset in the middle of a serial read
        idle(8'h07, 6);
        wr16(8'h01, 8'h07);
        wr16(8'h00, 8'h07);
        for (int i = 0; i < 3; i++) rd(16'h4016, 8'h07, rv, rdat);
        CPU_EN = 1'b1; CPU_ADDR = 16'h4016; CPU_RW_n = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(CPU_DOUT_VALID), 16'h0);
        chk("mid_rst_dout", 16'(CPU_DOUT), 16'h00);
        chk("mid_rst_buttons", 16'(buttons_dbg), 16'h00);
        model_reset();
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1; CPU_EN = 1'b0;
        rd(16'h4016, 8'h07, rv, rdat);
        chk("post_rst_rd", 16'(rdat), 16'h41);

        // randomized traffic against the model
        for (int blk = 0; blk < 80; blk++) begin
            int         sel;
            int         hold;
            logic [7:0] kc;
            sel  = $urandom_range(0, 9);
            kc   = (sel < 8) ? KEY_TAB[sel] : ((sel == 8) ? 8'h00 : 8'($urandom));
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                case ($urandom_range(0, 5))
                    0: cycle(1'b0, 16'($urandom), 8'($urandom), 1'($urandom), kc, rv, rdat);
                    1: rd(16'h4016, kc, rv, rdat);
                    2: wr16(8'($urandom), kc);
                    3: rd(16'h4017, kc, rv, rdat);
                    4: cycle(1'b1, 16'h4017, 8'($urandom), 1'b0, kc, rv, rdat);
                    default: cycle(1'b1, 16'($urandom), 8'($urandom), 1'($urandom), kc, rv, rdat);
                endcase
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
